pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid pipeline stage with registered in_ready and flush.
// Optional stall/flush statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 12,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [DATA_W-1:0]   main_data_q, main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q, skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
   logic                in_fire;
   logic                out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;

      if (flush) begin
         // Killed entries become bubbles; data registers keep their contents.
         state_d     = EMPTY;
         main_ctrl_d = '0;
         skid_ctrl_d = '0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (in_fire) begin
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
                  state_d     = TWO;
               end else if (out_fire) begin
                  state_d     = EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  state_d     = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      // Handshake outputs come straight from flops so in_ready never sees out_ready.
      in_ready_d  = (state_d != TWO);
      out_valid_d = (state_d != EMPTY);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = out_valid_q ? main_ctrl_q : '0;

`ifdef PIPE_STAGE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Both counters saturate at all-ones instead of wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
